bsg_fpu_cmp_pipe: RTL and testbench
===================================

Name: bsg_fpu_cmp_pipe

Overview:
Parametrised, pipelined floating-point compare/min/max unit for arbitrary IEEE-style formats (e_p exponent bits, m_p mantissa bits).
- Accepts one operation per cycle over a valid/ready input interface.
- Returns results over a valid/yumi output interface, two cycles later when there is no backpressure.
- Sits in the FPU next to the add/mul pipes. It replaces the single-format combinational compare with a throughput-1 pipelined unit that also carries an opcode and accumulates exception flags.

Parameters:
e_p, 8, exponent width (>=2)
m_p, 23, mantissa width (>=2)
sticky_flags_p, 1, 1 = maintain a sticky invalid flag register; 0 = the flag register is tied to 0

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
v_i  in  1  input valid
ready_o  out  1  unit can accept an input this cycle
op_i  in  3  operation: 0 EQ, 1 LT, 2 LE, 3 MIN, 4 MAX; 5-7 reserved
a_i  in  e_p+m_p+1  operand A {sign, exp, man}
b_i  in  e_p+m_p+1  operand B
v_o  out  1  result valid
yumi_i  in  1  consumer takes the result (only legal when v_o=1)
result_o  out  e_p+m_p+1  compare ops: {0..., bit}; MIN/MAX: selected operand or canonical NaN
invalid_o  out  1  invalid-operation flag for the result in the output stage
sticky_invalid_o  out  1  OR of invalid_o over all consumed results since reset or clear
clear_sticky_i  in  1  clears sticky_invalid_o

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-low (reset_n_i). All state is updated on the rising edge of clk_i.
- Reset (reset_n_i=0 at an edge):
  - stage-1 valid, stage-2 valid and sticky flag all become 0, so v_o=0 and sticky_invalid_o=0.
  - Data registers are don't-care; result_o and invalid_o are 0 whenever v_o=0.
  - A reset mid-operation discards all in-flight entries.
  - ready_o=0 while reset_n_i=0.
- Handshake:
  - Input fires on v_i & ready_o. Output fires on v_o & yumi_i.
  - ready_o = ~s1_v | ~s2_v | yumi_i. This is full throughput with bubble collapsing; there is no combinational path from v_i to ready_o.
- Stage 1 (registers on input fire):
  - Classify both operands: zero, nan, sig_nan, infty, sign.
  - Form 1-bit magnitude less-than on bits [e_p+m_p-1:0].
  - Form bitwise equality; register op_i.
- Stage 2 (advances when ~s2_v or yumi_i):
  - Compute the result from the stage-1 registers.
  - Latency is 2 cycles from input fire to v_o with no stall.
  - If stage 2 is held and stage 1 is full, stage 1 holds.
- Classification:
  - nan: exp all ones and man != 0.
  - sig_nan: nan and man MSB == 0.
  - zero: exp == 0 and man == 0.
- EQ:
  - Either operand NaN -> 0; invalid = either operand sig_nan.
  - Both operands zero -> 1 (so +0 == -0).
  - Otherwise bitwise equality.
- LT / LE:
  - Either operand NaN -> 0; invalid = 1.
  - Both zero -> LT 0, LE 1.
  - Signs differ -> a negative gives 1.
  - Both positive -> magnitude compare (LE includes equality).
  - Both negative -> reversed magnitude compare (LT = ~lt & ~eq; LE = ~lt | eq).
- MIN / MAX:
  - Both NaN -> canonical NaN {0, all ones, 1, 0...}; invalid = either operand sig_nan.
  - Exactly one NaN -> the other operand; invalid = the NaN operand's sig_nan.
  - Both zero -> MIN returns -0 if either sign is 1, MAX returns +0 unless both signs are 1.
  - Otherwise select using the LT rule.
- Reserved op: result 0, invalid 0; the handshake completes normally.
- Compare results are placed in result_o[0], with upper bits 0.
- Sticky flag:
  - Set on an output fire with invalid_o=1.
  - clear_sticky_i has priority over a set in the same cycle; a set in the following cycle is recorded.
- Simultaneous events:
  - Input fire and output fire in the same cycle with both stages full: the pipeline shifts, with no loss or duplication.
  - yumi_i while v_o=0 is illegal; an assertion flags it.

Decomposition:
- Package bsg_fpu_cmp_pkg: op enum (EQ/LT/LE/MIN/MAX), width helper function, canonical-NaN constant function of e_p/m_p.
- Sub-module: the parametrised classifier bsg_fpu_preprocess (e_p, m_p), instantiated twice in stage 1.
- Stage registers and selection logic stay in the top module.

Test Plan (e_p=5, m_p=10):
1. LT, a=0x3C00 (1.0), b=0x4000 (2.0), yumi_i=1 -> v_o=1 exactly 2 cycles after input fire, result_o=0x0001, invalid_o=0.
2. EQ, a=0x8000, b=0x0000 -> result_o=0x0001. MIN of the same pair -> result_o=0x8000. MAX of the same pair -> result_o=0x0000.
3. MIN, a=0x7D00 (sNaN), b=0xBC00 -> result_o=0xBC00, invalid_o=1, sticky_invalid_o=1 on the next cycle. MAX, a=0x7E00 (qNaN), b=0x7E00 (qNaN) -> result_o=0x7E00, invalid_o=0.
4. LT, a=0xC000 (-2), b=0xBC00 (-1) -> result_o=0x0001. LE with a=b=0xBC00 -> result_o=0x0001. LE, a=0x7E00 (qNaN), b=0x3C00 -> result_o=0, invalid_o=1.
5. Backpressure: stream 6 ops back-to-back with yumi_i=0 for 4 cycles. Required: ready_o drops after 2 accepted ops; results then emerge in order, one per cycle, with none dropped or duplicated.
6. reset_n_i=0 for one cycle with both stages full -> next cycle v_o=0 and sticky_invalid_o=0, ready_o=1 once reset_n_i=1.

Source files
------------

// File: rtl/bsg_fpu_cmp_pkg.sv
// Shared types and helpers for the pipelined FP compare/min/max unit.
package bsg_fpu_cmp_pkg;

  typedef enum logic [2:0] {
    OpEq  = 3'd0,
    OpLt  = 3'd1,
    OpLe  = 3'd2,
    OpMin = 3'd3,
    OpMax = 3'd4
  } fpu_cmp_op_e;

  localparam int unsigned MaxWidth = 128;

  typedef struct packed {
    logic sign;
    logic zero;
    logic nan;
    logic sig_nan;
    logic infty;
  } fp_class_t;

  function automatic int unsigned fp_width(input int unsigned e, input int unsigned m);
    return e + m + 1;
  endfunction

  // Quiet NaN with only the mantissa MSB set: {0, all ones, 1, 0...}.
  function automatic logic [MaxWidth-1:0] canonical_nan(input int unsigned e,
                                                        input int unsigned m);
    logic [MaxWidth-1:0] one;
    one = {{(MaxWidth-1){1'b0}}, 1'b1};
    return (((one << e) - one) << m) | (one << (m - 1));
  endfunction

endpackage

// File: rtl/bsg_fpu_preprocess.sv
// Classifies one IEEE-style operand into sign/zero/nan/sig_nan/infty.
module bsg_fpu_preprocess
  import bsg_fpu_cmp_pkg::*;
#(
  parameter int unsigned e_p = 8,
  parameter int unsigned m_p = 23
) (
  input  logic [e_p+m_p:0] a_i,
  output fp_class_t        class_o
);

  logic [e_p-1:0] exp_field;
  logic [m_p-1:0] man_field;
  logic           exp_ones, exp_zero, man_zero;

  assign exp_field = a_i[e_p+m_p-1:m_p];
  assign man_field = a_i[m_p-1:0];
  assign exp_ones  = &exp_field;
  assign exp_zero  = ~|exp_field;
  assign man_zero  = ~|man_field;

  always_comb begin
    class_o.sign    = a_i[e_p+m_p];
    class_o.zero    = exp_zero & man_zero;
    class_o.nan     = exp_ones & ~man_zero;
    class_o.sig_nan = exp_ones & ~man_zero & ~man_field[m_p-1];
    class_o.infty   = exp_ones & man_zero;
  end

endmodule

// File: rtl/bsg_fpu_cmp_pipe.sv
// Two-stage, throughput-1 FP compare/min/max pipe with valid/ready in, valid/yumi out
// and an optional sticky invalid flag.
module bsg_fpu_cmp_pipe
  import bsg_fpu_cmp_pkg::*;
#(
  parameter int unsigned e_p            = 8,
  parameter int unsigned m_p            = 23,
  parameter bit          sticky_flags_p = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             v_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [e_p+m_p:0] a_i,
  input  logic [e_p+m_p:0] b_i,
  output logic             v_o,
  input  logic             yumi_i,
  output logic [e_p+m_p:0] result_o,
  output logic             invalid_o,
  output logic             sticky_invalid_o,
  input  logic             clear_sticky_i
);

  localparam int unsigned Width = fp_width(e_p, m_p);
  localparam logic [Width-1:0] CanonNan = Width'(canonical_nan(e_p, m_p));

  logic             s1_v_q, s2_v_q;
  logic             in_fire, s2_adv, out_fire;
  fp_class_t        a_cls, b_cls, a_cls_q, b_cls_q;
  logic [2:0]       op_q;
  logic [Width-1:0] a_q, b_q;
  logic             lt_q, eq_q;
  logic [Width-1:0] result_d, result_q;
  logic             invalid_d, invalid_q;
  logic             sticky_q;

  assign ready_o  = reset_n_i & (~s1_v_q | ~s2_v_q | yumi_i);
  assign in_fire  = v_i & ready_o;
  assign s2_adv   = ~s2_v_q | yumi_i;
  assign out_fire = s2_v_q & yumi_i;

  bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) u_pre_a (.a_i(a_i), .class_o(a_cls));
  bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) u_pre_b (.a_i(b_i), .class_o(b_cls));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= in_fire | (s1_v_q & ~s2_adv);
      if (s2_adv) s2_v_q <= s1_v_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      op_q    <= op_i;
      a_q     <= a_i;
      b_q     <= b_i;
      a_cls_q <= a_cls;
      b_cls_q <= b_cls;
      lt_q    <= a_i[Width-2:0] < b_i[Width-2:0];
      eq_q    <= a_i == b_i;
    end
  end

  logic any_nan, any_snan, both_zero, lt_ord, le_ord, is_max, zero_sign;

  always_comb begin
    any_nan   = a_cls_q.nan | b_cls_q.nan;
    any_snan  = a_cls_q.sig_nan | b_cls_q.sig_nan;
    both_zero = a_cls_q.zero & b_cls_q.zero;
    is_max    = op_q == OpMax;
    zero_sign = is_max ? (a_cls_q.sign & b_cls_q.sign) : (a_cls_q.sign | b_cls_q.sign);
    // Ordering for non-NaN, not-both-zero operands; negatives reverse the magnitude order.
    if (a_cls_q.sign != b_cls_q.sign) begin
      lt_ord = a_cls_q.sign;
      le_ord = a_cls_q.sign;
    end else if (!a_cls_q.sign) begin
      lt_ord = lt_q;
      le_ord = lt_q | eq_q;
    end else begin
      lt_ord = ~lt_q & ~eq_q;
      le_ord = ~lt_q | eq_q;
    end

    result_d  = '0;
    invalid_d = 1'b0;
    case (op_q)
      OpEq: begin
        result_d[0] = ~any_nan & (both_zero | eq_q);
        invalid_d   = any_snan;
      end
      OpLt: begin
        result_d[0] = ~any_nan & ~both_zero & lt_ord;
        invalid_d   = any_nan;
      end
      OpLe: begin
        result_d[0] = ~any_nan & (both_zero | le_ord);
        invalid_d   = any_nan;
      end
      OpMin, OpMax: begin
        if (a_cls_q.nan && b_cls_q.nan) begin
          result_d  = CanonNan;
          invalid_d = any_snan;
        end else if (a_cls_q.nan) begin
          result_d  = b_q;
          invalid_d = a_cls_q.sig_nan;
        end else if (b_cls_q.nan) begin
          result_d  = a_q;
          invalid_d = b_cls_q.sig_nan;
        end else if (both_zero) begin
          result_d = {zero_sign, {(Width-1){1'b0}}};
        end else begin
          result_d = (lt_ord ^ is_max) ? a_q : b_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s2_adv && s1_v_q) begin
      result_q  <= result_d;
      invalid_q <= invalid_d;
    end
  end

  assign v_o       = s2_v_q;
  assign result_o  = s2_v_q ? result_q : '0;
  assign invalid_o = s2_v_q & invalid_q;

  if (sticky_flags_p) begin : g_sticky
    always_ff @(posedge clk_i) begin
      if (!reset_n_i)                  sticky_q <= 1'b0;
      else if (clear_sticky_i)         sticky_q <= 1'b0;
      else if (out_fire && invalid_q)  sticky_q <= 1'b1;
    end
  end else begin : g_no_sticky
    assign sticky_q = 1'b0;
  end

  assign sticky_invalid_o = sticky_q;

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       yumi_i |-> s2_v_q);

endmodule

// File: tb/tb_bsg_fpu_cmp_pipe.sv
// Self-checking bench for bsg_fpu_cmp_pipe at half precision (e_p=5, m_p=10).
module tb_bsg_fpu_cmp_pipe;
  import bsg_fpu_cmp_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         v_i = 1'b0, yumi_i = 1'b0, clear_sticky_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         ready_o, v_o, invalid_o, sticky_invalid_o;
  logic [W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  bsg_fpu_cmp_pipe #(.e_p(5), .m_p(10), .sticky_flags_p(1'b1)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .v_o(v_o), .yumi_i(yumi_i), .result_o(result_o),
    .invalid_o(invalid_o), .sticky_invalid_o(sticky_invalid_o),
    .clear_sticky_i(clear_sticky_i)
  );

  function automatic logic fnan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic fsnan(input logic [15:0] x);
    return fnan(x) && !x[9];
  endfunction

  // Signed ordering key: both zeros map to 0, negatives below positives.
  function automatic int fkey(input logic [15:0] x);
    int mag;
    mag = int'({17'd0, x[14:0]});
    return x[15] ? -mag : mag;
  endfunction

  // Reference: returns {invalid, result}.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic an, bn, as, bs;
    int ka, kb;
    an = fnan(a); bn = fnan(b); as = fsnan(a); bs = fsnan(b);
    ka = fkey(a); kb = fkey(b);
    case (op)
      3'd0: return an || bn ? {as | bs, 16'h0} : {1'b0, 15'd0, ka == kb};
      3'd1: return an || bn ? {1'b1, 16'h0} : {1'b0, 15'd0, ka < kb};
      3'd2: return an || bn ? {1'b1, 16'h0} : {1'b0, 15'd0, ka <= kb};
      3'd3, 3'd4: begin
        if (an && bn) return {as | bs, 16'h7E00};
        if (an) return {as, b};
        if (bn) return {bs, a};
        if (ka == 0 && kb == 0) begin
          if (op == 3'd3) return {1'b0, (a[15] | b[15]) ? 16'h8000 : 16'h0000};
          return {1'b0, (a[15] & b[15]) ? 16'h8000 : 16'h0000};
        end
        if (op == 3'd3) return {1'b0, (ka < kb) ? a : b};
        return {1'b0, (ka < kb) ? b : a};
      end
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [15:0] sp [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'hFE00,
                             16'h7D00, 16'hFD01, 16'h3C00, 16'hBC00, 16'h0001, 16'h8001};
    if ($urandom_range(0, 1) == 1) return sp[$urandom_range(0, 11)];
    return 16'($urandom);
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic want, input logic clr,
                       input logic rst_n);
    @(negedge clk);
    reset_n_i      = rst_n;
    v_i            = v;
    op_i           = op;
    a_i            = a;
    b_i            = b;
    yumi_i         = want & v_o;
    clear_sticky_i = clr;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 3'd0, 16'h0, 16'h0, 0, 0, 0);
    drive(0, 3'd0, 16'h0, 16'h0, 0, 0, 0);
    checks++;
    if (v_o !== 1'b0 || sticky_invalid_o !== 1'b0 || ready_o !== 1'b0 ||
        result_o !== 16'h0 || invalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v_o=%b sticky=%b ready=%b res=%h inv=%b, want 0 0 0 0000 0",
               v_o, sticky_invalid_o, ready_o, result_o, invalid_o);
    end
    drive(0, 3'd0, 16'h0, 16'h0, 0, 0, 1);
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b v_o=%b, want 1 0", ready_o, v_o);
    end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        inv;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [11];
    logic sticky_exp;
    vecs = '{
      '{3'd1, 16'h3C00, 16'h4000, 16'h0001, 1'b0},
      '{3'd0, 16'h8000, 16'h0000, 16'h0001, 1'b0},
      '{3'd3, 16'h8000, 16'h0000, 16'h8000, 1'b0},
      '{3'd4, 16'h8000, 16'h0000, 16'h0000, 1'b0},
      '{3'd3, 16'h7D00, 16'hBC00, 16'hBC00, 1'b1},
      '{3'd4, 16'h7E00, 16'h7E00, 16'h7E00, 1'b0},
      '{3'd1, 16'hC000, 16'hBC00, 16'h0001, 1'b0},
      '{3'd2, 16'hBC00, 16'hBC00, 16'h0001, 1'b0},
      '{3'd2, 16'h7E00, 16'h3C00, 16'h0000, 1'b1},
      '{3'd5, 16'h3C00, 16'h4000, 16'h0000, 1'b0},
      '{3'd0, 16'h7D00, 16'h7D00, 16'h0000, 1'b1}
    };
    drive(0, 3'd0, 16'h0, 16'h0, 1, 1, 1);
    sticky_exp = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1, vecs[i].op, vecs[i].a, vecs[i].b, 1, 0, 1);
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_ready: ready=%b, want 1", i, ready_o);
      end
      drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      checks++;
      if (v_o !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early: v_o=%b one cycle after fire, want 0", i, v_o);
      end
      drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      checks++;
      if (v_o !== 1'b1 || result_o !== vecs[i].res || invalid_o !== vecs[i].inv) begin
        errors++;
        $display("FAIL dir%0d_result: v=%b res=%h inv=%b, want v=1 res=%h inv=%b",
                 i, v_o, result_o, invalid_o, vecs[i].res, vecs[i].inv);
      end
      sticky_exp = sticky_exp | vecs[i].inv;
      drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      checks++;
      if (sticky_invalid_o !== sticky_exp || v_o !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_sticky: sticky=%b v_o=%b, want sticky=%b v_o=0",
                 i, sticky_invalid_o, v_o, sticky_exp);
      end
    end
  endtask

  task automatic test_sticky_clear();
    // Two invalid ops back to back; clear during the first output fire.
    drive(1, 3'd1, 16'h7E00, 16'h3C00, 1, 0, 1);
    drive(1, 3'd2, 16'h3C00, 16'h7E00, 1, 0, 1);
    drive(0, 3'd0, 16'h0, 16'h0, 1, 1, 1);
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    checks++;
    if (sticky_invalid_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear_priority: sticky=%b, want 0", sticky_invalid_o);
    end
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    checks++;
    if (sticky_invalid_o !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_after_clear: sticky=%b, want 1", sticky_invalid_o);
    end
    drive(0, 3'd0, 16'h0, 16'h0, 1, 1, 1);
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    checks++;
    if (sticky_invalid_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_idle_clear: sticky=%b, want 0", sticky_invalid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [15:0] as  [6] = '{16'h3C00, 16'hC000, 16'h7E00, 16'h8000, 16'h4000, 16'hBC00};
    logic [15:0] bs  [6] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'h7D00, 16'hC000};
    logic [16:0] exp_v;
    int idx = 0, outs = 0;
    logic drop_seen = 1'b0, fired;
    for (int c = 0; c < 40 && outs < 6; c++) begin
      if (idx < 6) drive(1, ops[idx], as[idx], bs[idx], c >= 4, 0, 1);
      else drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      if (!drop_seen && v_i && !ready_o) begin
        drop_seen = 1'b1;
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL bp_ready_drop: ready fell after %0d accepts, want 2", idx);
        end
      end
      fired = v_o && yumi_i;
      if (outs > 0) begin
        checks++;
        if (!fired) begin
          errors++;
          $display("FAIL bp_gap: no result in cycle %0d after %0d outputs, want one", c, outs);
        end
      end
      if (fired) begin
        exp_v = model(ops[outs], as[outs], bs[outs]);
        checks++;
        if ({invalid_o, result_o} !== exp_v) begin
          errors++;
          $display("FAIL bp_out%0d: inv=%b res=%h, want inv=%b res=%h",
                   outs, invalid_o, result_o, exp_v[16], exp_v[15:0]);
        end
        outs++;
      end
      if (v_i && ready_o) idx++;
    end
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    checks++;
    if (outs != 6 || !drop_seen || v_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: outs=%0d drop=%b v_o=%b, want 6 1 0", outs, drop_seen, v_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_v;
    int sent = 0;
    for (int c = 0; c < 60 && (sent < 20 || sb.size() > 0); c++) begin
      if (sent < 20)
        drive(1, 3'($urandom_range(0, 4)), rand_operand(), rand_operand(), 1, 0, 1);
      else drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      if (v_i) begin
        checks++;
        if (ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready: ready=%b in cycle %0d, want 1", ready_o, c);
        end
      end
      if (v_o && yumi_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result %h, want none", result_o);
        end else begin
          exp_v = sb.pop_front();
          if ({invalid_o, result_o} !== exp_v) begin
            errors++;
            $display("FAIL b2b_out: inv=%b res=%h, want inv=%b res=%h",
                     invalid_o, result_o, exp_v[16], exp_v[15:0]);
          end
        end
      end
      if (v_i && ready_o) begin
        sb.push_back(model(op_i, a_i, b_i));
        sent++;
      end
    end
    checks++;
    if (sb.size() != 0 || sent != 20) begin
      errors++;
      $display("FAIL b2b_drain: pending=%0d sent=%0d, want 0 20", sb.size(), sent);
    end
    sb.delete();
  endtask

  task automatic test_random();
    logic [16:0] exp_v;
    logic sticky_exp = 1'b0, fired_inv, clr;
    for (int c = 0; c < 460; c++) begin
      logic [15:0] a;
      a   = rand_operand();
      clr = (c == 0) || ($urandom_range(0, 19) == 0);
      if (c < 400)
        drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a,
              ($urandom_range(0, 7) == 0) ? a : rand_operand(),
              $urandom_range(0, 9) < 7, clr, 1);
      else drive(0, 3'd0, 16'h0, 16'h0, 1, clr, 1);
      if (c > 0) begin
        checks++;
        if (sticky_invalid_o !== sticky_exp) begin
          errors++;
          $display("FAIL rnd_sticky: sticky=%b in cycle %0d, want %b",
                   sticky_invalid_o, c, sticky_exp);
        end
      end
      if (!v_o) begin
        checks++;
        if (result_o !== 16'h0 || invalid_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle: res=%h inv=%b with v_o=0, want 0000 0", result_o, invalid_o);
        end
      end
      fired_inv = 1'b0;
      if (v_o && yumi_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: unexpected result %h, want none", result_o);
        end else begin
          exp_v = sb.pop_front();
          fired_inv = exp_v[16];
          if ({invalid_o, result_o} !== exp_v) begin
            errors++;
            $display("FAIL rnd_out: inv=%b res=%h, want inv=%b res=%h",
                     invalid_o, result_o, exp_v[16], exp_v[15:0]);
          end
        end
      end
      if (v_i && ready_o) sb.push_back(model(op_i, a_i, b_i));
      if (clr) sticky_exp = 1'b0;
      else if (fired_inv) sticky_exp = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: %0d results still pending, want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_inflight();
    drive(1, 3'd2, 16'h7E00, 16'h3C00, 1, 0, 1);
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    drive(1, 3'd1, 16'h3C00, 16'h4000, 0, 0, 1);
    drive(1, 3'd1, 16'h3C00, 16'h4000, 0, 0, 1);
    drive(1, 3'd1, 16'h3C00, 16'h4000, 0, 0, 1);
    checks++;
    if (v_o !== 1'b1 || ready_o !== 1'b0 || sticky_invalid_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_prefill: v_o=%b ready=%b sticky=%b, want 1 0 1",
               v_o, ready_o, sticky_invalid_o);
    end
    drive(0, 3'd0, 16'h0, 16'h0, 0, 0, 0);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_low: ready=%b during reset, want 0", ready_o);
    end
    drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
    checks++;
    if (v_o !== 1'b0 || sticky_invalid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 16'h0)
    begin
      errors++;
      $display("FAIL rst_flush: v_o=%b sticky=%b ready=%b res=%h, want 0 0 1 0000",
               v_o, sticky_invalid_o, ready_o, result_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 3'd0, 16'h0, 16'h0, 1, 0, 1);
      checks++;
      if (v_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_discard: v_o=%b %0d cycles after reset, want 0", v_o, k + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sticky_clear();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
